// File: rtl/mix_sched_if.sv
// mix_sched_if: request/grant/result bundle between two requesters and mix_sched.
//
// Handshake: a requester raises req[i] and holds its seed stable until it is
// granted. gnt is combinational and one-hot. A job is accepted at a rising edge
// where req[i] & gnt[i] is high. There is no back-pressure on the result side:
// done is a one-cycle pulse, and result/done_id are valid in that cycle.
// result then holds its value until the next done pulse.
interface mix_sched_if #(
  parameter int W = 32
);
  logic [1:0]     req;
  logic [8*W-1:0] seed0;
  logic [8*W-1:0] seed1;
  logic [1:0]     gnt;
  logic           busy;
  logic           done;
  logic           done_id;
  logic [8*W-1:0] result;

  modport master (
    output req, seed0, seed1,
    input  gnt, busy, done, done_id, result
  );

  modport slave (
    input  req, seed0, seed1,
    output gnt, busy, done, done_id, result
  );
endinterface

// File: rtl/mix_sched.sv
// mix_sched: round-robin arbiter plus a multi-cycle sequencer for the 8-lane mixer.
// The block runs one mixing round per clock for ROUNDS clocks, then one finalize
// clock, and returns the result with a done pulse tagged by requester.
// Optional feature macro: MIX_SCHED_FINAL_EN. When it is defined, the finalize
// step is a per-lane multiply-add. Otherwise finalize is a plain copy.
// The FSM state is visible on o_dbg_state: 0 = IDLE, 1 = RUN, 2 = FIN.
module mix_sched #(
  parameter int W      = 32,
  parameter int ROUNDS = 12
) (
  input  logic        i_clk,
  input  logic        i_rst,
  mix_sched_if.slave  io_bus,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam logic [7:0] LAST_RCNT = 8'(ROUNDS - 1);

  state_t       r_state;
  logic [W-1:0] r_lanes [8];
  logic [7:0]   r_rcnt;
  logic         r_last;
  logic         r_id;
  logic         r_busy;
  logic         r_done;
  logic         r_done_id;
  logic [8*W-1:0] r_result;

  logic [W-1:0] w_seed0 [8];
  logic [W-1:0] w_seed1 [8];
  logic [W-1:0] w_round [8];
  logic [W-1:0] w_final [8];
  logic [1:0]   w_gnt;
  logic         w_accept;

  // Unpack the seed buses into lane arrays. Lane i sits at [i*W +: W].
  for (genvar g = 0; g < 8; g++) begin : g_unpack
    assign w_seed0[g] = io_bus.seed0[g*W +: W];
    assign w_seed1[g] = io_bus.seed1[g*W +: W];
  end

  // Round-robin grant: offered only in IDLE and never while reset is high.
  always_comb begin
    w_gnt = 2'b00;
    if (!i_rst && r_state == ST_IDLE) begin
      case (io_bus.req)
        2'b01:   w_gnt = 2'b01;
        2'b10:   w_gnt = 2'b10;
        2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign w_accept = |(io_bus.req & w_gnt);

  // One full mixing round. Each step walks lanes 0..7 in order, so every lane
  // sees the already-updated values of the lanes before it.
  always_comb begin : p_round
    logic [W-1:0] o [8];
    o = r_lanes;
    for (int i = 0; i < 8; i++)
      o[3'(i)] = o[3'(i)] + o[3'(i+1)] - o[3'(i+5)];
    for (int i = 0; i < 8; i++)
      o[3'(i)] = o[3'(i)] ^ (o[3'(i+3)] << 16);
    for (int i = 0; i < 8; i++)
      o[3'(i)] = o[3'(i)] - (o[3'(i+2)] >> 17) + (o[3'(i+4)] >> 12);
    w_round = o;
  end

`ifdef MIX_SCHED_FINAL_EN
  localparam logic [W-1:0] FIN_M [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
  localparam logic [W-1:0] FIN_K [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

  // Finalize: per-lane multiply-add. Products are truncated to W bits.
  always_comb begin
    for (int i = 0; i < 8; i++)
      w_final[3'(i)] = r_lanes[3'(i)] * FIN_M[3'(i)] + FIN_K[3'(i)];
  end
`else
  // Finalize: lanes pass through unchanged. The latency is the same as with the multiply-add.
  always_comb begin
    w_final = r_lanes;
  end
`endif

  // Sequencer FSM with registered busy/done/result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_lanes   <= '{default: '0};
      r_rcnt    <= 8'd0;
      r_last    <= 1'b1;
      r_id      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_id <= 1'b0;
      r_result  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_lanes <= w_gnt[1] ? w_seed1 : w_seed0;
            r_id    <= w_gnt[1];
            r_last  <= w_gnt[1];
            r_rcnt  <= 8'd0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_lanes <= w_round;
          r_rcnt  <= r_rcnt + 8'd1;
          if (r_rcnt == LAST_RCNT) r_state <= ST_FIN;
        end
        ST_FIN: begin
          r_result  <= {w_final[7], w_final[6], w_final[5], w_final[4],
                        w_final[3], w_final[2], w_final[1], w_final[0]};
          r_done_id <= r_id;
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign io_bus.gnt     = w_gnt;
  assign io_bus.busy    = r_busy;
  assign io_bus.done    = r_done;
  assign io_bus.done_id = r_done_id;
  assign io_bus.result  = r_result;
  assign o_dbg_state    = r_state;

endmodule

// File: doc/mix_sched.md
# mix_sched

Multi-cycle sequencer and two-port arbiter for the 8-lane, 32-bit mixing datapath. Two requesters each present an 8-lane seed state. The block grants one requester at a time, round-robin. It iterates the mixing round `ROUNDS` times, one round per clock, then applies an optional multiply-add finalize stage and returns the result with a one-cycle done pulse tagged with the requester ID. It replaces the single-edge evaluation of the whole calculation with a pipelined-in-time schedule.

## Interface
- `W`, 32, lane width in bits.
- `ROUNDS`, 12, mixing rounds per job; legal range 1..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  2  request per requester; held high with stable seed until granted.
- `seed0`  in  8*W  requester 0 state; lane i at `[i*W +: W]`.
- `seed1`  in  8*W  requester 1 state; same packing.
- `gnt`  out  2  combinational one-hot grant; the job is accepted at the edge where `req[i]&gnt[i]`.
- `busy`  out  1  high in RUN and FIN.
- `done`  out  1  one-cycle pulse; `result` and `done_id` are valid in that cycle.
- `done_id`  out  1  requester of the completed job.
- `result`  out  8*W  final lane state; holds its value until the next done.

## Operation
FSM states and transitions:
- **IDLE:** `gnt` is driven from arbitration. On acceptance, latch the granted seed into lanes o0..o7, set `rcnt=0`, and go to RUN.
- **RUN:** apply one round per cycle and increment `rcnt`. On the edge where `rcnt==ROUNDS-1`, the last round is applied and the FSM goes to FIN.
- **FIN:** apply the finalize step, register `result`, `done_id`, and `done=1`, then return to IDLE.

Round definition. All ops are modulo 2^W. Updates within a step are sequential over i=0..7, so each lane uses the already-updated values of earlier lanes. Index arithmetic is mod 8.
- **A:** `oi = oi + o(i+1) - o(i+5)`
- **B:** `oi = oi ^ (o(i+3) << 16)`
- **C:** `oi = oi - (o(i+2) >> 17) + (o(i+4) >> 12)`. Shifts are logical.

Finalize: `oi = oi*M[i] + K[i]`, where M = 2,3,5,7,11,13,17,19 and K = 3,5,7,11,13,17,19,23. Products are truncated to W bits.

Arbitration:
- Round-robin with a `last` pointer.
- Single request: that requester is granted.
- Both requesting: grant the requester that is not `last`.
- Reset sets `last=1`, so requester 0 wins the first tie.
- `gnt=0` whenever the FSM is not in IDLE or `rst` is high.

Reset and boundary behaviour:
- Reset values: FSM=IDLE, `gnt=0`, `busy=0`, `done=0`, `done_id=0`, `result=0`, lanes=0, `rcnt=0`, `last=1`.
- `rst` mid-job aborts the job. No done pulse is issued and the requester is not re-granted automatically.
- `rst` has priority over every other event.
- `req` dropped before grant: no acceptance and no state change.
- `req` changes while busy are ignored.

## Timing
- Acceptance edge E0. Rounds are applied at E1..E_ROUNDS, finalize at E_(ROUNDS+1).
- `done` is high during the cycle after E_(ROUNDS+1).
- The FSM is in IDLE during the `done` cycle, so the next grant can be offered in that same cycle.
- Throughput: one job per `ROUNDS+2` cycles under continuous load.
- `busy` is high from after E0 through E_(ROUNDS+1).
- The round is the critical path (24 dependent add/xor stages). It must close in one cycle at the target clock; no internal pipelining.

## Configuration
- **`MIX_SCHED_FINAL_EN` defined:** FIN applies the multiply-add finalize.
- **`MIX_SCHED_FINAL_EN` undefined:** FIN copies the lanes to `result` unchanged. The multipliers are not synthesized. Latency and handshake are identical to the defined build.

## Test plan
- **Zero seed, finalize on:** with `MIX_SCHED_FINAL_EN` defined and `ROUNDS=1`, req0 with all-zero seed:
  - `gnt=01`; `done` 3 cycles after acceptance.
  - `result` lanes = 3,5,7,B,D,11,13,17 hex; `done_id=0`.
- **Single-bit seed, finalize off:** with `MIX_SCHED_FINAL_EN` undefined and `ROUNDS=1`, seed0 lane0=1, others 0:
  - `result` lanes = FFFF0011, FFFF8011, 00000000, FFFEFFFF, 0010FFF0, 0010FFF8, FFFF8002, 000F7FF1.
- **Tie arbitration:** both req held continuously from reset, `ROUNDS=12`:
  - Grants alternate 0,1,0,1.
  - `done` pulses every 14 cycles with `done_id` alternating, starting at 0.
- **Reset mid-run:** `rst` asserted for 1 cycle at round 5 of a job:
  - No `done` is issued; all outputs return to their reset values the next cycle.
  - A subsequent req1-only request is granted at the first IDLE cycle.
- **Request dropped:** req0 pulsed for one cycle while busy, then dropped:
  - No acceptance occurs; `gnt` stays 0 while busy.
  - `result` keeps its previous value.
- **Back-to-back:** req0 held across `done`:
  - `gnt[0]` is high in the `done` cycle.
  - The new job is accepted at that cycle's edge, with no idle gap beyond the FIN cycle.
